regfile_read_port: RTL and testbench
====================================

REGFILE_READ_PORT -- requirements
Module: regfile_read_port

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 64, meaning the operand width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning the register index width.
REQ-003 The block SHALL have parameter ZERO_REG, default 31, meaning the index that always reads as zero.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a read request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block accepts the request this cycle.
REQ-008 The block SHALL have ports rd_addr_a and rd_addr_b, input, ADDR_WIDTH bits each: the requested register indices.
REQ-009 The block SHALL have ports rf_addr_a and rf_addr_b, output, ADDR_WIDTH bits each: combinational pass-through of rd_addr_a and rd_addr_b to the register file read ports.
REQ-010 The block SHALL have ports rf_data_a and rf_data_b, input, DATA_WIDTH bits each: the combinational register file read data.
REQ-011 The block SHALL have ports wr_enable (1 bit), wr_addr (ADDR_WIDTH bits) and wr_data (DATA_WIDTH bits), all inputs: a snoop of the register file write port; the write commits at the same clk edge.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: response data is held.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: the consumer takes the response this cycle.
REQ-014 The block SHALL have ports rsp_data_a and rsp_data_b, output, DATA_WIDTH bits each: the registered operands.

Function
REQ-015 The block SHALL implement a two-state FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-016 The block SHALL drive req_ready = (state==EMPTY) || rsp_ready, with no dependency on req_valid.
REQ-017 A request SHALL be accepted when req_valid && req_ready; the captured operands appear on rsp_data_* with rsp_valid=1 one cycle later (latency 1).
REQ-018 Transitions SHALL be: EMPTY->FULL on accept; FULL->EMPTY on rsp_ready without accept; FULL->FULL on rsp_ready with accept (back-to-back, one response per cycle); FULL holds while rsp_ready=0.
REQ-019 Operand capture SHALL use this priority: address==ZERO_REG gives 0; else wr_enable && wr_addr==address gives wr_data (forwarding); else rf_data.
REQ-020 While FULL and not being replaced, a snooped write with wr_addr equal to a held operand address (not ZERO_REG) SHALL overwrite that held operand at the same edge, so held data never goes stale.
REQ-021 When rd_addr_a==rd_addr_b, both operands SHALL receive identical values under REQ-019 and REQ-020.
REQ-022 Writes to ZERO_REG SHALL never alter any response data.
REQ-023 rsp_data_* and rsp_valid SHALL be stable while rsp_valid && !rsp_ready, except for updates under REQ-020.

Reset
REQ-024 Asserting reset SHALL immediately force state=EMPTY, rsp_valid=0, rsp_data_a=0, rsp_data_b=0, and clear held addresses to ZERO_REG, independent of clk.
REQ-025 A reset asserted mid-transaction SHALL discard any held response; no response is emitted after reset deasserts until a new request is accepted.
REQ-026 While reset is high, req_ready SHALL be 1 (state EMPTY) but no request SHALL be captured.

Structure
REQ-027 DATA_WIDTH, ADDR_WIDTH, ZERO_REG defaults and the FSM state enum SHALL be defined in shared package regfile_pkg.
REQ-028 Per-operand capture, forwarding, held-address and snoop-update logic SHALL be one sub-module, read_operand_slot, instantiated twice (a and b).

Verification
REQ-029 Basic read: X5=0x1234 in the register file, request a=5, b=6 (X6=0xABCD), rsp_ready=1 -> next cycle rsp_valid=1, rsp_data_a=0x1234, rsp_data_b=0xABCD.
REQ-030 Forwarding: request a=7 in the same cycle as a write to X7 of 0xDEAD_BEEF (register file still returns the old value 0) -> rsp_data_a=0xDEAD_BEEF.
REQ-031 Zero register: request a=31, b=31 while writing 0xFFFF to X31 -> both operands 0.
REQ-032 Stall coherence: hold rsp_ready=0 with a=3 held, then write X3=0x55 -> rsp_data_a becomes 0x55 next cycle, rsp_valid stays 1, and req_ready=0 throughout the stall.
REQ-033 Throughput: req_valid=1 and rsp_ready=1 for 4 cycles with addresses 1,2,3,4 -> 4 consecutive responses with no bubbles, in order.
REQ-034 Reset mid-operation: assert reset while FULL with rsp_ready=0 -> rsp_valid=0 and data=0 immediately, without waiting for a clk edge; after release, no response appears until a new request is accepted.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and state encoding for the register-file read port.
package regfile_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_ZERO_REG   = 31;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rsp_state_e;
endpackage

// File: rtl/read_operand_slot.sv
// One held operand: capture with zero-reg/forwarding priority, then track
// later writes to the held address so the response never goes stale.
module read_operand_slot
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = DEF_ZERO_REG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_load,
  input  logic                  i_snoop_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rf_data,
  input  logic                  i_wr_enable,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0] o_data
);
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_capture;
  logic                  w_snoop_hit;

  always_comb begin
    if (i_rd_addr == ZERO_ADDR)
      w_capture = '0;
    else if (i_wr_enable && (i_wr_addr == i_rd_addr))
      w_capture = i_wr_data;
    else
      w_capture = i_rf_data;
  end

  // The zero register is never a valid snoop target.
  assign w_snoop_hit = i_snoop_en && i_wr_enable &&
                       (i_wr_addr == r_addr) && (r_addr != ZERO_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr <= ZERO_ADDR;
      r_data <= '0;
    end else if (i_load) begin
      r_addr <= i_rd_addr;
      r_data <= w_capture;
    end else if (w_snoop_hit) begin
      r_data <= i_wr_data;
    end
  end

  assign o_data = r_data;
endmodule

// File: rtl/regfile_read_port.sv
// Registered two-operand read port with write forwarding and a one-entry
// valid/ready response buffer supporting one response per cycle.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = DEF_ZERO_REG
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [ADDR_WIDTH-1:0] rf_addr_a,
  output logic [ADDR_WIDTH-1:0] rf_addr_b,
  input  logic [DATA_WIDTH-1:0] rf_data_a,
  input  logic [DATA_WIDTH-1:0] rf_data_b,
  input  logic                  wr_enable,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data_a,
  output logic [DATA_WIDTH-1:0] rsp_data_b
);
  rsp_state_e r_state;
  rsp_state_e w_state_next;
  logic       w_accept;
  logic       w_snoop_en;

  assign rf_addr_a = rd_addr_a;
  assign rf_addr_b = rd_addr_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_EMPTY;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_accept) w_state_next = ST_FULL;
      ST_FULL:  if (rsp_ready && !w_accept) w_state_next = ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == ST_EMPTY) || rsp_ready;
    rsp_valid  = (r_state == ST_FULL);
    w_accept   = req_valid && req_ready;
    w_snoop_en = (r_state == ST_FULL);
  end

  read_operand_slot #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_slot_a (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_snoop_en (w_snoop_en),
    .i_rd_addr  (rd_addr_a),
    .i_rf_data  (rf_data_a),
    .i_wr_enable(wr_enable),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_data     (rsp_data_a)
  );

  read_operand_slot #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH),
    .ZERO_REG  (ZERO_REG)
  ) u_slot_b (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_accept),
    .i_snoop_en (w_snoop_en),
    .i_rd_addr  (rd_addr_b),
    .i_rf_data  (rf_data_b),
    .i_wr_enable(wr_enable),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .o_data     (rsp_data_b)
  );
endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: a small register-file model, directed requests,
// and a queue of expected operand pairs consumed on each response handshake.
`timescale 1ns/1ps
module tb_regfile_read_port;
  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic [63:0] rf_data_a, rf_data_b;
  logic        wr_enable;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data_a, rsp_data_b;

  int checks = 0;
  int errors = 0;
  logic [127:0] exp_q [$];
  logic [63:0]  regs [32] = '{default: 64'h0};

  regfile_read_port dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .rf_addr_a (rf_addr_a),
    .rf_addr_b (rf_addr_b),
    .rf_data_a (rf_data_a),
    .rf_data_b (rf_data_b),
    .wr_enable (wr_enable),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data_a(rsp_data_a),
    .rsp_data_b(rsp_data_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: combinational read, write commits at the rising edge.
  assign rf_data_a = regs[rf_addr_a];
  assign rf_data_b = regs[rf_addr_b];
  always @(posedge clk) if (wr_enable) regs[wr_addr] <= wr_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a response is consumed when valid and ready both hold.
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got a=0x%0h b=0x%0h expected no response", rsp_data_a, rsp_data_b);
      end else begin
        logic [127:0] e;
        e = exp_q.pop_front();
        chk("rsp_data_a", rsp_data_a, e[127:64]);
        chk("rsp_data_b", rsp_data_b, e[63:0]);
      end
    end
  end

  task automatic step(input logic v, input logic [4:0] a, input logic [4:0] b,
                      input logic we, input logic [4:0] wa, input logic [63:0] wd,
                      input logic rr);
    req_valid = v;
    rd_addr_a = a;
    rd_addr_b = b;
    wr_enable = we;
    wr_addr   = wa;
    wr_data   = wd;
    rsp_ready = rr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 64'h0, rr);
  endtask

  function automatic logic [63:0] preload_val(input int i);
    case (i)
      1: return 64'h11;
      2: return 64'h22;
      3: return 64'h33;
      4: return 64'h44;
      5: return 64'h1234;
      default: return 64'hABCD;
    endcase
  endfunction

  initial begin
    reset = 1'b1; req_valid = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
    wr_enable = 1'b0; wr_addr = '0; wr_data = '0; rsp_ready = 1'b0;
    #1;
    chk("reset_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    chk("reset_data_a", rsp_data_a, 64'h0);
    chk("reset_data_b", rsp_data_b, 64'h0);
    chk("reset_req_ready", {63'b0, req_ready}, 64'd1);

    // Preload the register file while the DUT sits in reset with a request pending.
    for (int i = 1; i <= 6; i++) step(1'b1, 5'd5, 5'd6, 1'b1, 5'(i), preload_val(i), 1'b0);
    chk("reset_req_ready_hold", {63'b0, req_ready}, 64'd1);
    chk("reset_no_capture", {63'b0, rsp_valid}, 64'd0);
    req_valid = 1'b0;
    reset = 1'b0;
    idle(1'b1);
    chk("post_reset_empty", {63'b0, rsp_valid}, 64'd0);

    // Basic read, latency 1
    exp_q.push_back({64'h1234, 64'hABCD});
    step(1'b1, 5'd5, 5'd6, 1'b0, 5'd0, 64'h0, 1'b1);
    chk("latency_valid", {63'b0, rsp_valid}, 64'd1);
    idle(1'b1);

    // Forwarding from a same-cycle write
    exp_q.push_back({64'hDEAD_BEEF, 64'h1234});
    step(1'b1, 5'd7, 5'd5, 1'b1, 5'd7, 64'hDEAD_BEEF, 1'b1);
    idle(1'b1);

    // Zero register, with and without a write to it
    exp_q.push_back({64'h0, 64'h0});
    step(1'b1, 5'd31, 5'd31, 1'b1, 5'd31, 64'hFFFF, 1'b1);
    exp_q.push_back({64'h0, 64'h22});
    step(1'b1, 5'd31, 5'd2, 1'b0, 5'd0, 64'h0, 1'b1);
    idle(1'b1);

    // Identical addresses with forwarding
    exp_q.push_back({64'h77, 64'h77});
    step(1'b1, 5'd6, 5'd6, 1'b1, 5'd6, 64'h77, 1'b1);
    idle(1'b1);

    // Back-to-back throughput
    exp_q.push_back({64'h11, 64'h11});
    exp_q.push_back({64'h22, 64'h22});
    exp_q.push_back({64'h33, 64'h33});
    exp_q.push_back({64'h44, 64'h44});
    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 5'(i), 5'(i), 1'b0, 5'd0, 64'h0, 1'b1);
      chk("tput_no_bubble", {63'b0, rsp_valid}, 64'd1);
    end
    idle(1'b1);
    chk("tput_drained", {63'b0, rsp_valid}, 64'd0);

    // Stall coherence: held operand follows a write, zero-reg write ignored
    exp_q.push_back({64'h55, 64'h44});
    step(1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 64'h0, 1'b0);
    chk("stall_valid", {63'b0, rsp_valid}, 64'd1);
    step(1'b1, 5'd1, 5'd1, 1'b1, 5'd3, 64'h55, 1'b0);
    chk("stall_snoop_a", rsp_data_a, 64'h55);
    chk("stall_hold_b", rsp_data_b, 64'h44);
    chk("stall_valid_hold", {63'b0, rsp_valid}, 64'd1);
    chk("stall_req_ready", {63'b0, req_ready}, 64'd0);
    step(1'b1, 5'd1, 5'd1, 1'b1, 5'd31, 64'hBAD, 1'b0);
    chk("stall_zero_write_a", rsp_data_a, 64'h55);
    chk("stall_zero_write_b", rsp_data_b, 64'h44);
    chk("stall_req_ready2", {63'b0, req_ready}, 64'd0);
    idle(1'b1);
    chk("stall_drained", {63'b0, rsp_valid}, 64'd0);

    // Reset while FULL and stalled
    step(1'b1, 5'd5, 5'd6, 1'b0, 5'd0, 64'h0, 1'b0);
    chk("midrst_full", {63'b0, rsp_valid}, 64'd1);
    req_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("midrst_valid_async", {63'b0, rsp_valid}, 64'd0);
    chk("midrst_data_a_async", rsp_data_a, 64'h0);
    chk("midrst_data_b_async", rsp_data_b, 64'h0);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    chk("post_midrst_quiet", {63'b0, rsp_valid}, 64'd0);

    exp_q.push_back({64'h22, 64'h1234});
    step(1'b1, 5'd2, 5'd5, 1'b0, 5'd0, 64'h0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
